// File: rtl/l3_prefetch_read_queue_pkg.sv
// Shared widths, request-decision encoding and block-address helpers for the
// L3 prefetch read queue.
package l3_prefetch_read_queue_pkg;

  localparam int ADDR_WIDTH   = 48;
  localparam int BLOCK_OFFSET = 6;
  localparam int CONF_WIDTH   = 7;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [CONF_WIDTH-1:0] conf_t;

  typedef enum logic [1:0] {
    REQ_STALL,
    REQ_DUP,
    REQ_DROP,
    REQ_ENQ
  } req_action_e;

  localparam addr_t BLOCK_MASK = {{(ADDR_WIDTH-BLOCK_OFFSET){1'b1}}, {BLOCK_OFFSET{1'b0}}};

  function automatic addr_t block_align(input addr_t addr);
    return addr & BLOCK_MASK;
  endfunction

  function automatic logic same_block(input addr_t a, input addr_t b);
    return block_align(a) == block_align(b);
  endfunction

endpackage

// File: rtl/l3_prefetch_read_queue_if.sv
// Prefetcher-facing request port and L3 memory-request port of the read queue.
interface l3_prefetch_read_queue_if;
  import l3_prefetch_read_queue_pkg::*;

  addr_t       prefetch_address_in;
  logic        prefetch_valid_in;
  conf_t       prefetch_confidence_in;
  logic        prefetch_critical_in;
  logic        l3_read_queue_ack_out;
  logic        l3_read_queue_full_out;
  addr_t       mem_request_address_out;
  logic        mem_request_valid_out;
  logic        mem_request_ack_in;
  logic [15:0] duplicate_count_out;
  logic [15:0] drop_count_out;

  modport slave (
    input  prefetch_address_in, prefetch_valid_in, prefetch_confidence_in,
           prefetch_critical_in, mem_request_ack_in,
    output l3_read_queue_ack_out, l3_read_queue_full_out, mem_request_address_out,
           mem_request_valid_out, duplicate_count_out, drop_count_out
  );

  modport master (
    output prefetch_address_in, prefetch_valid_in, prefetch_confidence_in,
           prefetch_critical_in, mem_request_ack_in,
    input  l3_read_queue_ack_out, l3_read_queue_full_out, mem_request_address_out,
           mem_request_valid_out, duplicate_count_out, drop_count_out
  );

endinterface

// File: rtl/l3_prefetch_read_queue_class_fifo.sv
// One class FIFO of block addresses; exports every slot so the parent can run
// a duplicate CAM over queued entries.
module prefetch_class_fifo #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 48
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             push,
  input  logic [ADDR_WIDTH-1:0]            push_addr,
  input  logic                             pop,
  output logic [ADDR_WIDTH-1:0]            head,
  output logic [$clog2(DEPTH):0]           count,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] mem_q, mem_d;
  logic                             do_push, do_pop;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign head        = mem_q[rd_ptr_q];
  assign entry_valid = valid_q;
  assign entry_addr  = mem_q;

  // Fullness comes from the registered count, so a pop never makes room for a same-cycle push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every signal written here gets its default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q]   = push_addr;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: the address storage is deliberately not reset; valid_q alone decides which slots mean anything.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/l3_prefetch_read_queue.sv
// L3 receiver for SPP prefetches: duplicate filter, pressure-based drop, two
// priority classes and a single-entry memory-request output register.
module l3_prefetch_read_queue
  import l3_prefetch_read_queue_pkg::*;
#(
  parameter int FIFO_DEPTH         = 4,
  parameter int HIGH_WATERMARK     = 6,
  parameter int LOW_CONF_THRESHOLD = 50
) (
  input logic                      clk_in,
  input logic                      reset_in,
  l3_prefetch_read_queue_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  addr_t                  crit_head, norm_head, req_aligned;
  logic [CNT_W-1:0]       crit_count, norm_count;
  logic                   crit_full, crit_empty, norm_full, norm_empty;
  logic                   crit_push, crit_pop, norm_push, norm_pop;
  logic [FIFO_DEPTH-1:0]  crit_entry_valid, norm_entry_valid;
  addr_t [FIFO_DEPTH-1:0] crit_entry_addr, norm_entry_addr;

  req_action_e            action;
  logic                   cam_hit, load_out;
  logic [OCC_W-1:0]       occ_next;
  logic                   out_valid_q, out_valid_d, full_q, full_d;
  addr_t                  out_addr_q, out_addr_d;
  logic [15:0]            dup_cnt_q, dup_cnt_d, drop_cnt_q, drop_cnt_d;

  assign req_aligned = block_align(bus.prefetch_address_in);

  prefetch_class_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_crit_fifo (
    .clk_in(clk_in), .reset_in(reset_in), .push(crit_push), .push_addr(req_aligned),
    .pop(crit_pop), .head(crit_head), .count(crit_count), .full(crit_full),
    .empty(crit_empty), .entry_valid(crit_entry_valid), .entry_addr(crit_entry_addr)
  );

  prefetch_class_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_norm_fifo (
    .clk_in(clk_in), .reset_in(reset_in), .push(norm_push), .push_addr(req_aligned),
    .pop(norm_pop), .head(norm_head), .count(norm_count), .full(norm_full),
    .empty(norm_empty), .entry_valid(norm_entry_valid), .entry_addr(norm_entry_addr)
  );

  // Duplicate CAM spans both FIFOs and the entry already waiting in the output register.
  always_comb begin
    cam_hit = out_valid_q && same_block(out_addr_q, bus.prefetch_address_in);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (crit_entry_valid[i] && same_block(crit_entry_addr[i], bus.prefetch_address_in))
        cam_hit = 1'b1;
      if (norm_entry_valid[i] && same_block(norm_entry_addr[i], bus.prefetch_address_in))
        cam_hit = 1'b1;
    end
  end

  always_comb begin
    action = REQ_STALL;
    if (bus.prefetch_valid_in) begin
      if (cam_hit)
        action = REQ_DUP;
      else if (bus.prefetch_confidence_in < CONF_WIDTH'(LOW_CONF_THRESHOLD) && full_q)
        action = REQ_DROP;
      else if (bus.prefetch_critical_in ? !crit_full : !norm_full)
        action = REQ_ENQ;
    end
  end

  assign crit_push = (action == REQ_ENQ) && bus.prefetch_critical_in;
  assign norm_push = (action == REQ_ENQ) && !bus.prefetch_critical_in;

  // Output register refills when empty or when L3 takes the current request; critical wins.
  assign load_out = !out_valid_q || bus.mem_request_ack_in;
  assign crit_pop = load_out && !crit_empty;
  assign norm_pop = load_out && crit_empty && !norm_empty;

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    if (load_out) begin
      out_valid_d = crit_pop || norm_pop;
      if (crit_pop)      out_addr_d = crit_head;
      else if (norm_pop) out_addr_d = norm_head;
    end

    occ_next = OCC_W'(crit_count) + OCC_W'(norm_count) + OCC_W'(crit_push) + OCC_W'(norm_push)
             - OCC_W'(crit_pop) - OCC_W'(norm_pop);
    full_d   = (occ_next >= OCC_W'(HIGH_WATERMARK));

    dup_cnt_d  = dup_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (action == REQ_DUP && dup_cnt_q != 16'hFFFF)   dup_cnt_d  = dup_cnt_q + 16'd1;
    if (action == REQ_DROP && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      full_q      <= 1'b0;
      dup_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      full_q      <= full_d;
      dup_cnt_q   <= dup_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.l3_read_queue_ack_out   = (action != REQ_STALL);
  assign bus.l3_read_queue_full_out  = full_q;
  assign bus.mem_request_address_out = out_addr_q;
  assign bus.mem_request_valid_out   = out_valid_q;
  assign bus.duplicate_count_out     = dup_cnt_q;
  assign bus.drop_count_out          = drop_cnt_q;

endmodule

// File: tb/tb_l3_prefetch_read_queue.sv
// Directed bench for the L3 prefetch read queue; expected issue addresses go
// into a scoreboard queue and are matched as L3 accepts each memory request.
module tb_l3_prefetch_read_queue;
  import l3_prefetch_read_queue_pkg::*;

  logic  clk = 1'b0;
  logic  reset_in;
  int    total = 0;
  int    bad   = 0;
  addr_t exp_q[$];

  l3_prefetch_read_queue_if bus ();

  l3_prefetch_read_queue dut (
    .clk_in  (clk),
    .reset_in(reset_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not terminate");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted memory request must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset_in && bus.mem_request_valid_out && bus.mem_request_ack_in) begin
      check("issue_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("issue_addr", 64'(bus.mem_request_address_out), 64'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input addr_t addr, input int conf, input logic crit);
    bus.prefetch_address_in    = addr;
    bus.prefetch_confidence_in = conf_t'(conf);
    bus.prefetch_critical_in   = crit;
    bus.prefetch_valid_in      = 1'b1;
  endtask

  // Waits (bounded) for the consuming edge, then withdraws the request.
  task automatic wait_ack(input string tag, input int max, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.l3_read_queue_ack_out) break;
      waited++;
      if (waited >= max) break;
    end
    check({tag, "_acked"}, 64'(bus.l3_read_queue_ack_out), 64'd1);
    @(posedge clk);
    #1;
    bus.prefetch_valid_in = 1'b0;
  endtask

  task automatic send(input string tag, input addr_t addr, input int conf, input logic crit);
    int waited;
    drive_req(addr, conf, crit);
    wait_ack(tag, 8, waited);
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Single request with mem ack held high: immediate ack, valid two cycles later, one issue.
  task automatic issue_latency(input string tag, input addr_t raw, input addr_t aligned);
    int waited;
    exp_q.push_back(aligned);
    drive_req(raw, 80, 1'b0);
    wait_ack(tag, 4, waited);
    check({tag, "_ack_same_cycle"}, 64'(waited), 64'd0);
    check({tag, "_valid_n1"}, 64'(bus.mem_request_valid_out), 64'd0);
    step();
    check({tag, "_valid_n2"}, 64'(bus.mem_request_valid_out), 64'd1);
    check({tag, "_addr_n2"}, 64'(bus.mem_request_address_out), 64'(aligned));
    step();
    check({tag, "_single_issue"}, 64'(bus.mem_request_valid_out), 64'd0);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int waited;

    reset_in                   = 1'b1;
    bus.prefetch_address_in    = '0;
    bus.prefetch_valid_in      = 1'b0;
    bus.prefetch_confidence_in = '0;
    bus.prefetch_critical_in   = 1'b0;
    bus.mem_request_ack_in     = 1'b0;
    repeat (2) step();
    reset_in = 1'b0;
    step();
    check("rst_ack", 64'(bus.l3_read_queue_ack_out), 64'd0);
    check("rst_full", 64'(bus.l3_read_queue_full_out), 64'd0);
    check("rst_valid", 64'(bus.mem_request_valid_out), 64'd0);
    check("rst_addr", 64'(bus.mem_request_address_out), 64'd0);
    check("rst_dup", 64'(bus.duplicate_count_out), 64'd0);
    check("rst_drop", 64'(bus.drop_count_out), 64'd0);

    // Basic issue path and latency.
    bus.mem_request_ack_in = 1'b1;
    issue_latency("normal", 48'h1000_0047, 48'h1000_0040);

    // Same block at a different offset merges as a duplicate.
    bus.mem_request_ack_in = 1'b0;
    exp_q.push_back(48'h2000);
    send("dup_first", 48'h2000, 80, 1'b0);
    send("dup_second", 48'h2010, 80, 1'b0);
    check("dup_count", 64'(bus.duplicate_count_out), 64'd1);
    bus.mem_request_ack_in = 1'b1;
    drain("dup_drain", 10);
    repeat (2) step();
    check("dup_one_entry", 64'(bus.mem_request_valid_out), 64'd0);

    // Critical overtakes an older normal entry, but not the one already issued.
    bus.mem_request_ack_in = 1'b0;
    exp_q.push_back(48'h100);
    exp_q.push_back(48'h180);
    exp_q.push_back(48'h140);
    send("prio_a", 48'h100, 80, 1'b0);
    send("prio_b", 48'h140, 80, 1'b0);
    send("prio_c", 48'h180, 80, 1'b1);
    check("prio_head", 64'(bus.mem_request_address_out), 64'h100);
    bus.mem_request_ack_in = 1'b1;
    drain("prio_drain", 10);

    // Pressure: six queued entries raise full, low confidence drops, high confidence
    // still enqueues, and a full normal class stalls until a pop frees a slot.
    bus.mem_request_ack_in = 1'b0;
    step();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(48'h3000);
    exp_q.push_back(48'h3140);
    exp_q.push_back(48'h3180);
    exp_q.push_back(48'h3240);
    exp_q.push_back(48'h3040);
    exp_q.push_back(48'h3080);
    exp_q.push_back(48'h30c0);
    exp_q.push_back(48'h3100);
    exp_q.push_back(48'h3280);
    send("fill0", 48'h3000, 90, 1'b0);
    send("fill1", 48'h3040, 90, 1'b0);
    send("fill2", 48'h3080, 90, 1'b0);
    send("fill3", 48'h30c0, 90, 1'b0);
    send("fill4", 48'h3100, 90, 1'b0);
    check("below_watermark", 64'(bus.l3_read_queue_full_out), 64'd0);
    send("fill5", 48'h3140, 90, 1'b1);
    send("fill6", 48'h3180, 90, 1'b1);
    check("full_at_watermark", 64'(bus.l3_read_queue_full_out), 64'd1);
    send("drop_low_conf", 48'h3200, 30, 1'b0);
    check("drop_count", 64'(bus.drop_count_out), 64'd1);
    send("high_conf_enq", 48'h3240, 90, 1'b1);
    check("drop_count_hold", 64'(bus.drop_count_out), 64'd1);
    drive_req(48'h3280, 90, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_norm_full", 64'(bus.l3_read_queue_ack_out), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.mem_request_ack_in = 1'b1;
    wait_ack("stall_release", 20, waited);
    check("stall_needed_pops", 64'(waited >= 3), 64'd1);
    drain("pressure_drain", 20);
    step();
    check("full_cleared", 64'(bus.l3_read_queue_full_out), 64'd0);

    // Reset with both classes full and a request stuck in the output register.
    bus.mem_request_ack_in = 1'b0;
    send("rf0", 48'h4000, 90, 1'b0);
    send("rf1", 48'h4040, 90, 1'b0);
    send("rf2", 48'h4080, 90, 1'b0);
    send("rf3", 48'h40c0, 90, 1'b0);
    send("rf4", 48'h4100, 90, 1'b0);
    send("rf5", 48'h4140, 90, 1'b1);
    send("rf6", 48'h4180, 90, 1'b1);
    send("rf7", 48'h41c0, 90, 1'b1);
    send("rf8", 48'h4200, 90, 1'b1);
    check("rf_full", 64'(bus.l3_read_queue_full_out), 64'd1);
    check("rf_valid", 64'(bus.mem_request_valid_out), 64'd1);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    check("mid_rst_ack", 64'(bus.l3_read_queue_ack_out), 64'd0);
    check("mid_rst_full", 64'(bus.l3_read_queue_full_out), 64'd0);
    check("mid_rst_valid", 64'(bus.mem_request_valid_out), 64'd0);
    check("mid_rst_addr", 64'(bus.mem_request_address_out), 64'd0);
    check("mid_rst_dup", 64'(bus.duplicate_count_out), 64'd0);
    check("mid_rst_drop", 64'(bus.drop_count_out), 64'd0);
    bus.mem_request_ack_in = 1'b1;
    issue_latency("post_rst", 48'h5000, 48'h5000);
    repeat (3) step();
    check("no_stale_issue", 64'(bus.mem_request_valid_out), 64'd0);

    // Duplicate counter saturation.
    bus.mem_request_ack_in = 1'b0;
    exp_q.push_back(48'h6000);
    send("sat_seed", 48'h6000, 80, 1'b0);
    check("sat_start", 64'(bus.duplicate_count_out), 64'd0);
    drive_req(48'h6000, 80, 1'b0);
    repeat (65533) @(posedge clk);
    step();
    check("sat_fffe", 64'(bus.duplicate_count_out), 64'hFFFE);
    step();
    check("sat_ffff", 64'(bus.duplicate_count_out), 64'hFFFF);
    repeat (4464) @(posedge clk);
    step();
    check("sat_hold", 64'(bus.duplicate_count_out), 64'hFFFF);
    bus.prefetch_valid_in  = 1'b0;
    bus.mem_request_ack_in = 1'b1;
    drain("sat_drain", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l3_prefetch_read_queue.md
Name: l3_prefetch_read_queue

Overview:
- L3-side receiver for prefetch requests issued by the SPP prefetcher; drives the prefetcher's l3_read_queue_ack_in and l3_read_queue_full_in inputs.
- Buffers block-aligned prefetch addresses in two FIFOs (critical, normal), filters duplicates, drops low-confidence requests under pressure, and issues one request at a time to the L3 memory-request port over a valid/ack handshake.

Parameters:
ADDR_WIDTH, 48, physical address width
BLOCK_OFFSET, 6, log2 of cache block bytes; low bits zeroed on enqueue
CONF_WIDTH, 7, confidence width (0..100)
FIFO_DEPTH, 4, entries per class FIFO (power of 2)
HIGH_WATERMARK, 6, total occupancy at which full_out asserts
LOW_CONF_THRESHOLD, 50, confidence below this is droppable

Ports:
clk_in  input  1  clock
reset_in  input  1  synchronous active-high reset
prefetch_address_in  input  ADDR_WIDTH  prefetch address from prefetcher
prefetch_valid_in  input  1  request valid; held until ack
prefetch_confidence_in  input  CONF_WIDTH  request confidence
prefetch_critical_in  input  1  critical-class request
l3_read_queue_ack_out  output  1  request consumed this cycle (enqueued, merged or dropped)
l3_read_queue_full_out  output  1  total occupancy >= HIGH_WATERMARK (registered)
mem_request_address_out  output  ADDR_WIDTH  block-aligned address to L3
mem_request_valid_out  output  1  memory request valid
mem_request_ack_in  input  1  L3 accepts memory request
duplicate_count_out  output  16  saturating count of merged duplicates
drop_count_out  output  16  saturating count of low-confidence drops

Behaviour:
- Clock clk_in; reset reset_in synchronous, active-high.
- Reset: both FIFOs empty, output register invalid; ack_out=0, full_out=0, mem_request_valid_out=0, mem_request_address_out=0, both counters 0. Reset mid-handshake abandons the in-flight memory request (valid drops the next cycle, no retry).
- ack_out is combinational from the current-cycle request and registered state; a request is consumed in the cycle where valid_in and ack_out are both 1.
- Request decision, priority order, evaluated when valid_in=1:
  1. Duplicate: the block address matches a valid entry in either FIFO or the valid output register -> ack=1, discard, duplicate_count++.
  2. confidence < LOW_CONF_THRESHOLD and full_out=1 -> ack=1, discard, drop_count++.
  3. Target FIFO (critical if critical_in, else normal) not full -> ack=1, enqueue the aligned address.
  4. Otherwise ack=0 (stall); the producer holds the request.
- FIFO full is evaluated from the registered count; a same-cycle pop does not free space for a same-cycle push.
- full_out is registered: the next-cycle value equals (crit_count + norm_count after this edge) >= HIGH_WATERMARK.
- Output register loads when it is empty or mem_request_ack_in=1 in the same cycle. Source: head of the critical FIFO if non-empty, else head of the normal FIFO.
- Address and valid stay stable until ack.
- Minimum latency: accept at cycle N, enqueue at edge N, load at edge N+1, mem_request_valid_out=1 in cycle N+2. Back-to-back issue at one per cycle when ack is held high.
- Counters saturate at 16'hFFFF.
- Compare on bits [ADDR_WIDTH-1:BLOCK_OFFSET] only.

Decomposition:
- Shared package/header holds ADDR_WIDTH, BLOCK_OFFSET, CONF_WIDTH and the block-address extraction function.
- One sub-module, prefetch_class_fifo, is instantiated twice.
  - Parameters: DEPTH, ADDR_WIDTH.
  - Interface: push, pop, head, count, full, empty, plus per-entry valid/address vectors exported for the duplicate CAM.
- Top level holds the CAM compare, request decision, issue arbiter, output register and counters.

Test Plan:
- Normal request 0x1000_0047, conf 80, not critical, mem ack held 1 -> ack_out=1 in the same cycle; mem_request_address_out=0x1000_0040 and valid=1 two cycles later; one issue only.
- Duplicate: send 0x2000 then 0x2010 with mem ack held 0 -> both acked; one entry queued; duplicate_count_out=1.
- Priority: enqueue normal 0x100, 0x140, then critical 0x180, with mem ack 0 until all are queued (0x100 already in output register) -> issue order 0x100, 0x180, 0x140.
- Pressure: fill to 6 entries (full_out=1), then conf 30 -> acked and dropped, drop_count_out=1; then conf 90 to a non-full FIFO -> enqueued; full normal FIFO and conf 90 normal -> ack_out=0 until a pop frees a slot.
- Fill both FIFOs, hold mem ack 0, assert reset_in for 1 cycle -> all outputs 0 the next cycle; a fresh request afterward issues with the 2-cycle latency.
- 70000 duplicates -> duplicate_count_out saturates at 0xFFFF.
